// File: rtl/fifo_thresh.sv
// -----------------------------------------------------------------------------
// fifo_thresh
//
// Single-clock show-ahead FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds and a synchronous flush. A write while
// full is accepted only when a read happens in the same cycle. Full and empty
// are decided from the count alone, never from pointer equality.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, sticky overflow/underflow flags are kept.
//   When undefined, both outputs are tied to 0.
//
// Parameters:
//   B      data word width in bits
//   W      address bits, depth = 2**W
//   AF_LVL almost_full  when count >= AF_LVL
//   AE_LVL almost_empty when count <= AE_LVL
//
// Ports:
//   clk          system clock, rising edge
//   rst_i        synchronous active-high reset
//   clear_i      synchronous flush (memory contents untouched)
//   wr / rd      write / read request (rd acknowledges current r_data)
//   w_data       write data
//   r_data       show-ahead read data, mem[r_ptr]
//   empty, full, almost_empty, almost_full, count   status
//   overflow, underflow                             sticky error flags
// -----------------------------------------------------------------------------
module fifo_thresh #(
    parameter int unsigned B      = 8,
    parameter int unsigned W      = 4,
    parameter int unsigned AF_LVL = 2**W - 2,
    parameter int unsigned AE_LVL = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] L_DEPTH = (W+1)'(2**W);
    localparam logic [W:0] L_AF    = (W+1)'(AF_LVL);
    localparam logic [W:0] L_AE    = (W+1)'(AE_LVL);

    logic [B-1:0] r_mem [0:2**W-1];
    logic [W-1:0] r_w_ptr;
    logic [W-1:0] r_r_ptr;
    logic [W:0]   r_count;
    logic         r_empty;
    logic         r_full;
    logic         r_almost_empty;
    logic         r_almost_full;

    logic         w_flush;
    logic         w_wr_acc;
    logic         w_rd_acc;
    logic [W:0]   w_next_count;

    assign w_flush  = rst_i | clear_i;
    // A write into a full FIFO is only safe when a read frees a slot this cycle.
    assign w_wr_acc = wr & (~r_full | rd);
    assign w_rd_acc = rd & ~r_empty;

    assign w_next_count = r_count + (W+1)'(w_wr_acc) - (W+1)'(w_rd_acc);

    // Storage has no reset; flush only moves pointers.
    always_ff @(posedge clk) begin
        if (!w_flush && w_wr_acc) begin
            r_mem[r_w_ptr] <= w_data;
        end
    end

    // Flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_w_ptr        <= '0;
            r_r_ptr        <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_w_ptr <= r_w_ptr + W'(1);
            end
            if (w_rd_acc) begin
                r_r_ptr <= r_r_ptr + W'(1);
            end
            r_count        <= w_next_count;
            r_empty        <= (w_next_count == '0);
            r_full         <= (w_next_count == L_DEPTH);
            r_almost_empty <= (w_next_count <= L_AE);
            r_almost_full  <= (w_next_count >= L_AF);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && r_full && !rd) begin
                r_overflow <= 1'b1;
            end
            if (rd && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign r_data       = r_mem[r_r_ptr];
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;

endmodule

// File: tb/tb_fifo_thresh.sv
// -----------------------------------------------------------------------------
// tb_fifo_thresh
//
// Directed self-checking bench for fifo_thresh (B=8, W=4). Inputs change 1ns
// after the rising edge and outputs are sampled at that same point.
// Expected error-flag values follow FIFO_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_fifo_thresh;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       clear_i;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_thresh #(
        .B      (8),
        .W      (4),
        .AF_LVL (14),
        .AE_LVL (1)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .wr           (wr),
        .rd           (rd),
        .w_data       (w_data),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr      = 1'b0;
        rd      = 1'b0;
        clear_i = 1'b0;
        rst_i   = 1'b0;
        w_data  = 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        wr     = 1'b1;
        w_data = d;
        tick();
        wr     = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL reset_empty got %b want 1", empty); n_errors++;
        end
        n_checks++;
        if (almost_empty !== 1'b1) begin
            $display("FAIL reset_almost_empty got %b want 1", almost_empty); n_errors++;
        end
        n_checks++;
        if (full !== 1'b0) begin
            $display("FAIL reset_full got %b want 0", full); n_errors++;
        end
        n_checks++;
        if (almost_full !== 1'b0) begin
            $display("FAIL reset_almost_full got %b want 0", almost_full); n_errors++;
        end
        n_checks++;
        if (count !== 5'd0) begin
            $display("FAIL reset_count got %0d want 0", count); n_errors++;
        end
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL reset_err_flags got %b%b want 00", overflow, underflow); n_errors++;
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            n_checks++;
            if (count !== 5'(i + 1)) begin
                $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); n_errors++;
            end
            n_checks++;
            if (almost_full !== ((i + 1) >= 14)) begin
                $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full,
                         ((i + 1) >= 14)); n_errors++;
            end
            n_checks++;
            if (almost_empty !== ((i + 1) <= 1)) begin
                $display("FAIL fill_almost_empty[%0d] got %b want %b", i, almost_empty,
                         ((i + 1) <= 1)); n_errors++;
            end
            n_checks++;
            if (full !== ((i + 1) == 16) || empty !== 1'b0) begin
                $display("FAIL fill_full_empty[%0d] got %b%b want %b0", i, full, empty,
                         ((i + 1) == 16)); n_errors++;
            end
            n_checks++;
            if (r_data !== 8'h00) begin
                $display("FAIL fill_r_data[%0d] got %h want 00", i, r_data); n_errors++;
            end
        end
        // Write while full with no read: dropped.
        push(8'hAA);
        n_checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            $display("FAIL overfill_count got %0d/%b want 16/1", count, full); n_errors++;
        end
        n_checks++;
        if (overflow !== EXP_ERR) begin
            $display("FAIL overfill_overflow got %b want %b", overflow, EXP_ERR); n_errors++;
        end
        n_checks++;
        if (r_data !== 8'h00) begin
            $display("FAIL overfill_r_data got %h want 00", r_data); n_errors++;
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp;
        wr     = 1'b1;
        rd     = 1'b1;
        w_data = 8'h55;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        n_checks++;
        if (r_data !== 8'h01) begin
            $display("FAIL full_rw_r_data got %h want 01", r_data); n_errors++;
        end
        n_checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            $display("FAIL full_rw_count got %0d/%b want 16/1", count, full); n_errors++;
        end
        n_checks++;
        if (overflow !== EXP_ERR) begin
            $display("FAIL full_rw_overflow got %b want %b", overflow, EXP_ERR); n_errors++;
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'(k + 1) : 8'h55;
            n_checks++;
            if (r_data !== exp) begin
                $display("FAIL drain_r_data[%0d] got %h want %h", k, r_data, exp); n_errors++;
            end
            pop();
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            $display("FAIL drain_empty got %b/%0d want 1/0", empty, count); n_errors++;
        end
        n_checks++;
        if (underflow !== 1'b0) begin
            $display("FAIL drain_underflow got %b want 0", underflow); n_errors++;
        end
    endtask

    task automatic test_empty_rw();
        wr     = 1'b1;
        rd     = 1'b1;
        w_data = 8'h3C;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        n_checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            $display("FAIL empty_rw_count got %0d/%b want 1/0", count, empty); n_errors++;
        end
        n_checks++;
        if (r_data !== 8'h3C) begin
            $display("FAIL empty_rw_r_data got %h want 3c", r_data); n_errors++;
        end
        n_checks++;
        if (underflow !== EXP_ERR) begin
            $display("FAIL empty_rw_underflow got %b want %b", underflow, EXP_ERR); n_errors++;
        end
        pop();
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL empty_rw_drain got %b want 1", empty); n_errors++;
        end
        // Leave flags clean for the following scenarios.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nw = 0;
        int nr = 0;
        int cnt = 0;
        int cyc = 0;
        logic wacc;
        logic racc;
        while (nr < 20 && cyc < 100) begin
            wr     = (nw < 20);
            rd     = (cyc % 2 == 1) || (nw >= 20);
            w_data = 8'(nw);
            wacc   = wr && (cnt < 16 || rd);
            racc   = rd && (cnt > 0);
            if (racc) begin
                n_checks++;
                if (r_data !== 8'(nr)) begin
                    $display("FAIL wrap_r_data[%0d] got %h want %h", nr, r_data, 8'(nr));
                    n_errors++;
                end
            end
            tick();
            if (wacc) nw++;
            if (racc) nr++;
            cnt = cnt + int'(wacc) - int'(racc);
            cyc++;
            n_checks++;
            if (count !== 5'(cnt) || count > 5'd16) begin
                $display("FAIL wrap_count[%0d] got %0d want %0d", cyc, count, cnt);
                n_errors++;
            end
        end
        wr = 1'b0;
        rd = 1'b0;
        n_checks++;
        if (nr != 20) begin
            $display("FAIL wrap_timeout got %0d reads want 20", nr); n_errors++;
        end
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL wrap_end_empty got %b want 1", empty); n_errors++;
        end
    endtask

    task automatic test_flush(input bit use_rst);
        for (int i = 0; i < 16; i++) push(8'(i + 8'h80));
        push(8'hAA);
        for (int i = 0; i < 7; i++) pop();
        n_checks++;
        if (count !== 5'd9 || overflow !== EXP_ERR) begin
            $display("FAIL flush_setup[%0d] got %0d/%b want 9/%b", use_rst, count, overflow,
                     EXP_ERR); n_errors++;
        end
        if (use_rst) rst_i = 1'b1;
        else         clear_i = 1'b1;
        wr     = 1'b1;
        w_data = 8'hEE;
        tick();
        idle_inputs();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
            $display("FAIL flush_state[%0d] got %0d/%b/%b want 0/1/1", use_rst, count, empty,
                     almost_empty); n_errors++;
        end
        n_checks++;
        if (overflow !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
            $display("FAIL flush_flags[%0d] got %b/%b/%b want 0/0/0", use_rst, overflow, full,
                     almost_full); n_errors++;
        end
        tick();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            $display("FAIL flush_write_ignored[%0d] got %0d/%b want 0/1", use_rst, count,
                     empty); n_errors++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_back_to_back();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
